// File: rtl/mdu_pkg.sv
// Shared encodings for the HI/LO multiply/divide unit: opcodes, FSM states, counter width.
package mdu_pkg;

  localparam int unsigned NB_DATA_DEF = 32;
  localparam int unsigned NB_CNT      = $clog2(NB_DATA_DEF);

  typedef enum logic [2:0] {
    MDU_MULT  = 3'b000,
    MDU_MULTU = 3'b001,
    MDU_DIV   = 3'b010,
    MDU_DIVU  = 3'b011,
    MDU_MTHI  = 3'b100,
    MDU_MTLO  = 3'b101
  } mdu_op_e;

  typedef enum logic [1:0] {
    StIdle,
    StCalc,
    StFix
  } mdu_state_e;

endpackage

// File: rtl/mdu_div_core.sv
// Unsigned restoring divider: one quotient bit per step, operands are magnitudes.
module mdu_div_core #(
  parameter int unsigned NB_DATA = 32
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               load,
  input  logic               step,
  input  logic [NB_DATA-1:0] dividend,
  input  logic [NB_DATA-1:0] divisor,
  output logic [NB_DATA-1:0] quotient,
  output logic [NB_DATA-1:0] remainder
);

  logic [NB_DATA-1:0] rem_q, quo_q, dvs_q;
  logic [NB_DATA:0]   shifted;
  logic [NB_DATA+1:0] diff;
  logic               fits;

  // Extra top bit on diff acts as the borrow flag of the trial subtraction.
  assign shifted = {rem_q, quo_q[NB_DATA-1]};
  assign diff    = {1'b0, shifted} - {2'b00, dvs_q};
  assign fits    = ~diff[NB_DATA+1];

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rem_q <= '0;
      quo_q <= '0;
      dvs_q <= '0;
    end else if (load) begin
      rem_q <= '0;
      quo_q <= dividend;
      dvs_q <= divisor;
    end else if (step) begin
      rem_q <= fits ? diff[NB_DATA-1:0] : shifted[NB_DATA-1:0];
      quo_q <= {quo_q[NB_DATA-2:0], fits};
    end
  end

  assign quotient  = quo_q;
  assign remainder = rem_q;

endmodule

// File: rtl/mult_div_unit.sv
// Iterative HI/LO multiply/divide unit: shift-add multiply, restoring divide, MTHI/MTLO,
// sign fix-up on magnitudes at the end of the iteration.
module mult_div_unit
  import mdu_pkg::*;
#(
  parameter int unsigned NB_DATA = 32,
  parameter int unsigned NB_OP   = 3
) (
  input  logic               clk,
  input  logic               i_rst_n,
  input  logic               i_start,
  input  logic [NB_OP-1:0]   i_op,
  input  logic [NB_DATA-1:0] i_rs,
  input  logic [NB_DATA-1:0] i_rt,
  input  logic               i_flush,
  output logic               o_busy,
  output logic               o_done,
  output logic [NB_DATA-1:0] o_hi,
  output logic [NB_DATA-1:0] o_lo
);

  localparam int unsigned CntW = $clog2(NB_DATA);

  mdu_state_e state_q, state_d;

  logic [CntW-1:0]    cnt_q;
  logic               is_div_q, rs_neg_q, res_neg_q, dz_q, done_q;
  logic [NB_DATA-1:0] mcand_q, prod_hi_q, prod_lo_q, hi_q, lo_q;

  logic               accept, launch, signed_op, rs_neg, rt_neg, last;
  logic [NB_DATA-1:0] rs_mag, rt_mag, quo, rem;
  logic [NB_DATA:0]   mul_sum;

  logic [2*NB_DATA-1:0] prod;
  logic [NB_DATA-1:0]   res_hi, res_lo, quo_fix, rem_fix;

  assign accept    = (state_q == StIdle) & i_start & ~i_flush;
  assign launch    = accept & ~i_op[2];
  assign signed_op = ~i_op[0];
  assign rs_neg    = signed_op & i_rs[NB_DATA-1];
  assign rt_neg    = signed_op & i_rt[NB_DATA-1];
  // abs(most-negative) wraps to itself, which reads correctly as an unsigned magnitude.
  assign rs_mag    = rs_neg ? -i_rs : i_rs;
  assign rt_mag    = rt_neg ? -i_rt : i_rt;
  assign last      = (cnt_q == CntW'(NB_DATA - 1));

  // Multiplier lives in prod_lo_q and is shifted out as product bits shift in.
  assign mul_sum = {1'b0, prod_hi_q} + {1'b0, (prod_lo_q[0] ? mcand_q : '0)};

  mdu_div_core #(
    .NB_DATA (NB_DATA)
  ) u_div_core (
    .clk       (clk),
    .rst_n     (i_rst_n),
    .load      (launch),
    .step      ((state_q == StCalc) & is_div_q),
    .dividend  (rs_mag),
    .divisor   (rt_mag),
    .quotient  (quo),
    .remainder (rem)
  );

  always_ff @(posedge clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      state_q <= StIdle;
    end else begin
      state_q <= state_d;
    end
  end

  always_comb begin
    state_d = state_q;
    unique case (state_q)
      StIdle:  if (launch) state_d = StCalc;
      StCalc:  if (i_flush) state_d = StIdle;
               else if (last) state_d = StFix;
      StFix:   state_d = StIdle;
      default: state_d = StIdle;
    endcase
  end

  // Remainder follows the dividend's sign; divide-by-zero leaves HI = rs via that same path.
  always_comb begin
    prod    = {prod_hi_q, prod_lo_q};
    prod    = res_neg_q ? -prod : prod;
    quo_fix = res_neg_q ? -quo : quo;
    rem_fix = rs_neg_q ? -rem : rem;
    res_hi  = prod[2*NB_DATA-1:NB_DATA];
    res_lo  = prod[NB_DATA-1:0];
    if (is_div_q) begin
      res_hi = rem_fix;
      res_lo = dz_q ? '1 : quo_fix;
    end
  end

  always_ff @(posedge clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      cnt_q     <= '0;
      is_div_q  <= 1'b0;
      rs_neg_q  <= 1'b0;
      res_neg_q <= 1'b0;
      dz_q      <= 1'b0;
      done_q    <= 1'b0;
      mcand_q   <= '0;
      prod_hi_q <= '0;
      prod_lo_q <= '0;
      hi_q      <= '0;
      lo_q      <= '0;
    end else begin
      done_q <= 1'b0;
      if (launch) begin
        cnt_q     <= '0;
        is_div_q  <= i_op[1];
        rs_neg_q  <= rs_neg;
        res_neg_q <= rs_neg ^ rt_neg;
        dz_q      <= (i_rt == '0);
        mcand_q   <= rs_mag;
        prod_hi_q <= '0;
        prod_lo_q <= rt_mag;
      end else if (state_q == StCalc) begin
        cnt_q <= cnt_q + CntW'(1);
        if (!is_div_q) begin
          prod_hi_q <= mul_sum[NB_DATA:1];
          prod_lo_q <= {mul_sum[0], prod_lo_q[NB_DATA-1:1]};
        end
      end

      if (accept && (i_op[2:0] == MDU_MTHI)) begin
        hi_q <= i_rs;
      end else if (accept && (i_op[2:0] == MDU_MTLO)) begin
        lo_q <= i_rs;
      end else if ((state_q == StFix) && !i_flush) begin
        hi_q   <= res_hi;
        lo_q   <= res_lo;
        done_q <= 1'b1;
      end
    end
  end

  assign o_busy = (state_q != StIdle);
  assign o_done = done_q;
  assign o_hi   = hi_q;
  assign o_lo   = lo_q;

endmodule

// File: tb/tb_mult_div_unit.sv
// Scoreboard bench for mult_div_unit: directed corner cases plus random ops vs a 64-bit model.
module tb_mult_div_unit;

  logic        clk = 1'b0;
  logic        i_rst_n, i_start, i_flush;
  logic [2:0]  i_op;
  logic [31:0] i_rs, i_rt;
  logic        o_busy, o_done;
  logic [31:0] o_hi, o_lo;

  always #5 clk = ~clk;

  mult_div_unit #(
    .NB_DATA (32),
    .NB_OP   (3)
  ) dut (
    .clk     (clk),
    .i_rst_n (i_rst_n),
    .i_start (i_start),
    .i_op    (i_op),
    .i_rs    (i_rs),
    .i_rt    (i_rt),
    .i_flush (i_flush),
    .o_busy  (o_busy),
    .o_done  (o_done),
    .o_hi    (o_hi),
    .o_lo    (o_lo)
  );

  logic [63:0] sb[$];
  int          checks = 0;
  int          errors = 0;
  logic [31:0] cur_hi = '0;
  logic [31:0] cur_lo = '0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  // Returns {hi, lo} from plain 64-bit arithmetic.
  function automatic logic [63:0] ref_model(input logic [2:0] op, input logic [31:0] rs,
                                            input logic [31:0] rt);
    longint      a, b;
    logic [63:0] p, q, r;
    case (op)
      3'd0: begin a = longint'($signed(rs)); b = longint'($signed(rt)); p = a * b; return p; end
      3'd1: begin p = {32'b0, rs} * {32'b0, rt}; return p; end
      3'd2: begin
        if (rt == 32'd0) return {rs, 32'hFFFF_FFFF};
        a = longint'($signed(rs));
        b = longint'($signed(rt));
        q = a / b;
        r = a % b;
        return {r[31:0], q[31:0]};
      end
      3'd3: begin
        if (rt == 32'd0) return {rs, 32'hFFFF_FFFF};
        return {rs % rt, rs / rt};
      end
      default: return 64'd0;
    endcase
  endfunction

  always @(negedge clk) begin
    if (i_rst_n && o_done) begin
      if (sb.size() == 0) begin
        checks++;
        errors++;
        $display("FAIL unexpected_done: got done=1 expected no pending result");
      end else begin
        logic [63:0] e;
        e = sb.pop_front();
        check("result_hi", o_hi, e[63:32]);
        check("result_lo", o_lo, e[31:0]);
        cur_hi = e[63:32];
        cur_lo = e[31:0];
      end
    end
  end

  task automatic wait_idle();
    int n = 0;
    while (o_busy && n < 200) begin
      @(negedge clk);
      n++;
    end
    if (o_busy) begin
      checks++;
      errors++;
      $display("FAIL busy_timeout: got busy=1 expected idle within 200 cycles");
    end
  endtask

  task automatic issue(input logic [2:0] op, input logic [31:0] rs, input logic [31:0] rt,
                       input bit push);
    wait_idle();
    i_op    = op;
    i_rs    = rs;
    i_rt    = rt;
    i_start = 1'b1;
    if (push && op < 3'd4) sb.push_back(ref_model(op, rs, rt));
    @(negedge clk);
    i_start = 1'b0;
    if (op == 3'd4 || op == 3'd5) begin
      if (op == 3'd4) cur_hi = rs;
      else cur_lo = rs;
      check("mt_hi", o_hi, cur_hi);
      check("mt_lo", o_lo, cur_lo);
      check("mt_busy", {31'b0, o_busy}, 32'd0);
    end
  endtask

  task automatic drain();
    int n = 0;
    while ((sb.size() != 0 || o_busy) && n < 300) begin
      @(negedge clk);
      n++;
    end
    check("drain_pending", sb.size(), 0);
  endtask

  function automatic logic [31:0] pick_operand();
    case ($urandom_range(0, 7))
      0:       return 32'd0;
      1:       return 32'h8000_0000;
      2:       return 32'hFFFF_FFFF;
      3:       return 32'($urandom_range(0, 20));
      default: return $urandom;
    endcase
  endfunction

  initial begin
    #2_000_000;
    $display("FAIL watchdog: got no finish expected completion");
    $fatal(1, "watchdog");
  end

  initial begin
    int busy_cnt, done_cnt, done_at;
    i_rst_n = 1'b0;
    i_start = 1'b0;
    i_flush = 1'b0;
    i_op    = '0;
    i_rs    = '0;
    i_rt    = '0;
    repeat (3) @(negedge clk);
    check("reset_busy", {31'b0, o_busy}, 32'd0);
    check("reset_done", {31'b0, o_done}, 32'd0);
    check("reset_hi", o_hi, 32'd0);
    check("reset_lo", o_lo, 32'd0);
    i_rst_n = 1'b1;
    @(negedge clk);

    // MULT -3 * 7 with cycle-accurate busy/done timing.
    issue(3'd0, 32'hFFFF_FFFD, 32'd7, 1'b1);
    busy_cnt = 1;
    done_cnt = 0;
    done_at  = 0;
    if (!o_busy) busy_cnt = 0;
    for (int k = 2; k <= 40; k++) begin
      @(negedge clk);
      if (o_busy) busy_cnt++;
      if (o_done) begin
        done_cnt++;
        if (done_at == 0) done_at = k;
      end
    end
    check("busy_cycles", busy_cnt, 33);
    check("done_pulses", done_cnt, 1);
    check("done_cycle", done_at, 34);

    issue(3'd1, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 1'b1);
    issue(3'd2, 32'hFFFF_FFF9, 32'd2, 1'b1);
    issue(3'd3, 32'd7, 32'd0, 1'b1);
    issue(3'd2, 32'h8000_0000, 32'hFFFF_FFFF, 1'b1);
    issue(3'd2, 32'hFFFF_FFF9, 32'd0, 1'b1);
    drain();
    issue(3'd4, 32'h1234, 32'd0, 1'b1);
    issue(3'd5, 32'h5678, 32'd0, 1'b1);
    issue(3'd6, 32'hDEAD, 32'd1, 1'b1);
    check("reserved_hi", o_hi, cur_hi);
    check("reserved_busy", {31'b0, o_busy}, 32'd0);

    // Flush mid-divide: no result, HI/LO preserved.
    issue(3'd2, 32'd1000, 32'd7, 1'b0);
    repeat (9) @(negedge clk);
    i_flush = 1'b1;
    @(negedge clk);
    i_flush = 1'b0;
    @(negedge clk);
    check("flush_busy", {31'b0, o_busy}, 32'd0);
    check("flush_hi", o_hi, cur_hi);
    check("flush_lo", o_lo, cur_lo);
    repeat (40) @(negedge clk);

    // Start together with flush is refused.
    i_op    = 3'd0;
    i_rs    = 32'd5;
    i_rt    = 32'd5;
    i_start = 1'b1;
    i_flush = 1'b1;
    @(negedge clk);
    i_start = 1'b0;
    i_flush = 1'b0;
    check("start_flush_busy", {31'b0, o_busy}, 32'd0);

    // Repeated starts while busy are ignored.
    issue(3'd3, 32'd100, 32'd7, 1'b1);
    i_op    = 3'd1;
    i_rs    = 32'hABCD_0123;
    i_rt    = 32'd9;
    i_start = 1'b1;
    repeat (5) @(negedge clk);
    i_start = 1'b0;
    drain();

    // Reset in the middle of a multiply clears everything.
    issue(3'd0, 32'h0123_4567, 32'h89AB_CDEF, 1'b0);
    repeat (19) @(negedge clk);
    i_rst_n = 1'b0;
    #1;
    check("midreset_busy", {31'b0, o_busy}, 32'd0);
    check("midreset_hi", o_hi, 32'd0);
    check("midreset_lo", o_lo, 32'd0);
    @(negedge clk);
    i_rst_n = 1'b1;
    cur_hi = '0;
    cur_lo = '0;
    repeat (40) @(negedge clk);
    check("midreset_done", {31'b0, o_done}, 32'd0);

    for (int n = 0; n < 60; n++) begin
      issue(3'($urandom_range(0, 5)), pick_operand(), pick_operand(), 1'b1);
    end
    drain();
    check("final_hi", o_hi, cur_hi);
    check("final_lo", o_lo, cur_lo);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
